// File: rtl/conv_fft_stream_ctrl.sv
// conv_fft_stream_ctrl: write/read sequencer for FFT beats into image memory with output FIFO drain
//   Ports: clk, reset (sync, active-high); start/ctx_length arm a context of 1..2^ADDR_W beats;
//   fft_next_out marks a beat valid next cycle; output_fifo_full stalls read issue.
//   Outputs: we/write_address/write_bank, read_en/read_address/read_bank, output_valid,
//   ctx_done, busy, overflow (sticky drop flag), cfg_err (rejected start).
//   Build option: define CONV_FFT_PINGPONG_EN for two ping-pong banks; default is a single bank.
module conv_fft_stream_ctrl #(
  parameter int ADDR_W = 13
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [31:0]       ctx_length,
  input  logic              fft_next_out,
  input  logic              output_fifo_full,
  output logic              we,
  output logic [ADDR_W-1:0] write_address,
  output logic              write_bank,
  output logic              read_en,
  output logic [ADDR_W-1:0] read_address,
  output logic              read_bank,
  output logic              output_valid,
  output logic              ctx_done,
  output logic              busy,
  output logic              overflow,
  output logic              cfg_err
);
`ifdef CONV_FFT_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  logic [ADDR_W-1:0] r_last, r_wcnt, r_rcnt, r_waddr;
  logic [1:0]        r_full;
  logic              r_armed, r_wb, r_rb, r_we, r_wbank, r_wlast, r_valid, r_done, r_ovf, r_cfg;
  logic              w_busy, w_len_ok, w_start_ok, w_acc, w_wend, w_rd, w_rend;
  logic [1:0]        w_set, w_clr;
  assign w_busy     = (|r_full) | (r_wcnt != '0);
  assign w_len_ok   = (ctx_length != 32'd0) && (ctx_length <= (32'd1 << ADDR_W));
  assign w_start_ok = start & ~w_busy & w_len_ok;
  assign w_acc      = fft_next_out & r_armed & ~r_full[r_wb];
  assign w_wend     = w_acc & (r_wcnt == r_last);
  // full is set on the edge that launches the last write; hold off reading that bank
  // until the last beat has actually landed in memory.
  assign w_rd       = r_full[r_rb] & ~output_fifo_full & ~reset &
                      ~(r_we & r_wlast & (r_wbank == r_rb));
  assign w_rend     = w_rd & (r_rcnt == r_last);
  assign w_set      = w_wend ? (2'b01 << r_wb) : 2'b00;
  assign w_clr      = w_rend ? (2'b01 << r_rb) : 2'b00;
  always_ff @(posedge clk) begin
    if (reset) begin
      r_last  <= '0;
      r_wcnt  <= '0;
      r_rcnt  <= '0;
      r_waddr <= '0;
      r_full  <= '0;
      r_armed <= 1'b0;
      r_wb    <= 1'b0;
      r_rb    <= 1'b0;
      r_we    <= 1'b0;
      r_wbank <= 1'b0;
      r_wlast <= 1'b0;
      r_valid <= 1'b0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
      r_cfg   <= 1'b0;
    end else begin
      r_we    <= w_acc;
      r_wlast <= w_wend;
      if (w_acc) begin
        r_waddr <= r_wcnt;
        r_wbank <= r_wb;
      end
      r_wcnt  <= w_wend ? '0 : w_acc ? r_wcnt + ADDR_W'(1) : r_wcnt;
      r_rcnt  <= w_rend ? '0 : w_rd ? r_rcnt + ADDR_W'(1) : r_rcnt;
      r_full  <= (r_full | w_set) & ~w_clr;
      r_valid <= w_rd;
      r_done  <= w_rend;
      r_cfg   <= start & ~w_busy & ~w_len_ok;
      if (w_start_ok) begin
        // store len-1 so a full 2^ADDR_W context fits the counter width
        r_last  <= ctx_length[ADDR_W-1:0] - ADDR_W'(1);
        r_armed <= 1'b1;
        r_wb    <= 1'b0;
        r_rb    <= 1'b0;
        r_ovf   <= 1'b0;
      end else begin
        r_wb    <= w_wend ? (PP & ~r_wb) : r_wb;
        r_rb    <= w_rend ? (PP & ~r_rb) : r_rb;
        r_ovf   <= r_ovf | (fft_next_out & ~w_acc);
      end
    end
  end
  assign we            = r_we;
  assign write_address = r_waddr;
  assign write_bank    = r_wbank;
  assign read_en       = w_rd;
  assign read_address  = r_rcnt;
  assign read_bank     = r_rb;
  assign output_valid  = r_valid;
  assign ctx_done      = r_done;
  assign busy          = w_busy;
  assign overflow      = r_ovf;
  assign cfg_err       = r_cfg;
endmodule

// File: doc/conv_fft_stream_ctrl.md
# conv_fft_stream_ctrl

Sequencer for the image-FFT stage of the convolution layer. It tracks FFT output beats into the image memory blocks, produces their write enable and write/read addresses, and drains each finished context to the output FIFO under backpressure. Two banks in ping-pong let context N+1 be written while context N is read. It sits between the four 2D FFT units, the image memory blocks and the output FIFO, and replaces the ad-hoc write/read counters in the FFT layer.

## Interface
Parameters:
- ADDR_W, 13, per-bank address width; a context holds 1..2^ADDR_W beats.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, synchronous, active-high.
- start  in  1  one-cycle pulse; latches ctx_length and arms the writer.
- ctx_length  in  32  beats per context.
- fft_next_out  in  1  AND of all FFT `next_out`; the beat is valid on the memory inputs the following cycle.
- output_fifo_full  in  1  downstream backpressure.
- we  out  1  memory write enable.
- write_address  out  ADDR_W  write beat index.
- write_bank  out  1  bank being written.
- read_en  out  1  memory read issue.
- read_address  out  ADDR_W  read beat index.
- read_bank  out  1  bank being read.
- output_valid  out  1  read data valid at memory output.
- ctx_done  out  1  one-cycle pulse on the last beat of a context.
- busy  out  1  any bank full, or a write context is in progress.
- overflow  out  1  sticky; a beat was dropped.
- cfg_err  out  1  one-cycle pulse; start was rejected.

## Operation
- State registers: len (latched length), armed, wb, rb, full[1:0], wcnt, rcnt.
- Start acceptance:
  - start is accepted only when busy=0.
  - ctx_length=0 or ctx_length>2^ADDR_W: start is rejected, cfg_err=1 the next cycle, state is unchanged.
  - If accepted: len<=ctx_length, armed<=1, wb=rb=0.
  - start while busy=1 is ignored, with no error.
- Writer:
  - If fft_next_out arrives at cycle t and the beat is accepted: at t+1, we=1, write_address=wcnt, write_bank=wb, and wcnt increments.
  - Drop rule: if armed=0, or full[wb]=1 at t, the beat is dropped. we stays 0 and overflow is set. overflow is cleared only by reset or an accepted start.
  - When the beat with wcnt=len-1 is written: full[wb]<=1, wb toggles, wcnt<=0. armed stays 1 for following contexts.
- Reader:
  - Issue condition: full[rb]=1 and output_fifo_full=0. On issue, read_en=1, read_address=rcnt, read_bank=rb, rcnt increments.
  - Issuing rcnt=len-1 completes the context: full[rb]<=0, rb toggles, rcnt<=0.
- A set of full[wb] and a clear of full[rb] in the same cycle both take effect. They cannot target the same bank.
- busy = full[0] | full[1] | (wcnt!=0).
- Address arithmetic is ADDR_W bits. len=2^ADDR_W is handled by comparing a counter value of len-1, so addresses never wrap mid-context.

## Timing
- Reset value of every output is 0. All internal state is 0, and overflow is cleared.
- Write latency: fft_next_out -> we is exactly 1 cycle.
- Read latency: read_en -> output_valid is exactly 1 cycle, matching the memory read latency.
- ctx_done is asserted in the same cycle as output_valid for the last beat.
- Earliest read: the first read_en occurs in the cycle after the last write.
- Backpressure:
  - output_fifo_full is sampled in the issue cycle.
  - A read already issued always completes, so the FIFO must hold 1 beat of slack.
- Throughput is 1 beat/cycle per side when fft_next_out is continuous and the FIFO is never full.
- Reset mid-operation: reset wins in the same cycle. All contexts are discarded, and no further we or output_valid is produced.

## Configuration
- CONV_FFT_PINGPONG_EN defined: two banks as above; write_bank and read_bank toggle.
- CONV_FFT_PINGPONG_EN undefined:
  - Single bank; write_bank and read_bank are tied to 0.
  - The writer may not start the next context until the reader clears full[0]. Beats arriving meanwhile are dropped and set overflow.
  - Ports are unchanged in both builds.

## Test plan
- Basic context: start with ctx_length=4, then 4 consecutive fft_next_out -> we on cycles t+1..t+4 with addresses 0..3 on bank 0; read_en addresses 0..3; output_valid for 4 cycles; ctx_done on the 4th; busy returns to 0.
- Backpressure: len=8, output_fifo_full held high for 5 cycles mid-read -> no read_en while full, no beat lost, read addresses 0..7 in order, exactly 8 output_valid.
- Ping-pong overlap (PINGPONG_EN): len=16, continuous 32 beats -> bank 1 written while bank 0 is read, 2 ctx_done pulses, overflow=0. Without PINGPONG_EN, the same stimulus sets overflow=1.
- Overflow: both banks full, FIFO held full, 1 extra fft_next_out -> we stays 0, overflow=1, and overflow stays set after the banks drain.
- Config error: start with ctx_length=0, then with 8193 (ADDR_W=13) -> cfg_err pulses, busy=0, a following beat is dropped with overflow=1.
- Reset mid-read: len=8, assert reset after 3 output_valid -> next cycle all outputs 0; after a new start with len=2, a clean 2-beat context completes.
